// File: rtl/logo_pkg.sv
// Shared constants and scan state encoding for the logo column scanner.
package logo_pkg;

  localparam int LOGO_ROWS = 38;
  localparam int LOGO_COLS = 251;
  localparam int COL_IDX_W = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4,
    NEXT  = 3'd5
  } scan_state_t;

endpackage

// File: rtl/logo_column_scanner_ser_bit_timer.sv
// Half-period timer for the LED chain shift clock; owns the ser_clk level and
// strobes the last cycle of each low (tick_rise) and high (tick_fall) half.
module ser_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic shift_i,
  output logic ser_clk_o,
  output logic tick_rise_o,
  output logic tick_fall_o
);

  localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             term;

  assign term = (cnt_q == '0);

  // The level only toggles while shifting, so LATCH times a low half without a pulse.
  always_comb begin
    cnt_d   = RELOAD;
    phase_d = 1'b0;
    if (run_i) begin
      cnt_d = term ? RELOAD : cnt_q - DIV_W'(1);
      if (shift_i) phase_d = term ? ~phase_q : phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign ser_clk_o   = phase_q;
  assign tick_rise_o = run_i & term & ~phase_q;
  assign tick_fall_o = run_i & term & phase_q;

endmodule

// File: rtl/logo_column_scanner.sv
// Steps the logo ROM column index and shifts each column into the LED chain.
// Optional LOGO_SCROLL_EN adds a per-frame column offset (one-column scroll).
module logo_column_scanner
  import logo_pkg::*;
#(
  parameter int COLS        = LOGO_COLS,
  parameter int ROWS        = LOGO_ROWS,
  parameter int CLK_DIV     = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic [COL_IDX_W-1:0] col_idx,
  input  logic [ROWS-1:0]      col_data,
  output logic                 ser_data,
  output logic                 ser_clk,
  output logic                 ser_latch,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BIT_W  = $clog2(ROWS + 1);
  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [COL_IDX_W-1:0] LAST_COL  = COL_IDX_W'(COLS - 1);

  if (COLS < 1 || COLS > (1 << COL_IDX_W)) begin : g_cols_chk
    $error("logo_column_scanner: COLS must be in 1..1024");
  end
  if (CLK_DIV < 1) begin : g_div_chk
    $error("logo_column_scanner: CLK_DIV must be at least 1");
  end

  scan_state_t          state_q, state_d;
  logic [ROWS-1:0]      shreg_q, shreg_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [COL_IDX_W-1:0] col_q, col_d;
  logic [COL_IDX_W-1:0] col_idx_q, col_idx_d;
  logic                 busy_q, latch_q, fd_q;
  logic                 tick_rise, tick_fall;

  ser_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run_i      ((state_q == SHIFT) || (state_q == LATCH)),
    .shift_i    (state_q == SHIFT),
    .ser_clk_o  (ser_clk),
    .tick_rise_o(tick_rise),
    .tick_fall_o(tick_fall)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    col_d   = col_q;
    case (state_q)
      IDLE:  if (enable) state_d = FETCH;
      FETCH: begin
        shreg_d = col_data;
        bit_d   = BIT_W'(ROWS);
        state_d = SHIFT;
      end
      SHIFT: if (tick_fall) begin
        shreg_d = {shreg_q[ROWS-2:0], 1'b0};
        bit_d   = bit_q - BIT_W'(1);
        if (bit_q == BIT_W'(1)) state_d = LATCH;
      end
      LATCH: if (tick_rise) begin
        if (HOLD_CYCLES == 0) begin
          state_d = NEXT;
        end else begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = NEXT;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      NEXT: begin
        col_d   = (col_q == LAST_COL) ? '0 : col_q + COL_IDX_W'(1);
        state_d = enable ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LOGO_SCROLL_EN
  logic [COL_IDX_W-1:0] off_q, off_d;
  logic [COL_IDX_W:0]   sum;

  always_comb begin
    off_d = off_q;
    if (state_q == NEXT && col_q == LAST_COL)
      off_d = (off_q == LAST_COL) ? '0 : off_q + COL_IDX_W'(1);
  end

  // Both operands are below COLS, so a single conditional subtract wraps the sum.
  assign sum       = {1'b0, col_d} + {1'b0, off_d};
  assign col_idx_d = (sum >= (COL_IDX_W+1)'(COLS)) ? COL_IDX_W'(sum - (COL_IDX_W+1)'(COLS))
                                                   : sum[COL_IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) off_q <= '0;
    else     off_q <= off_d;
  end
`else
  assign col_idx_d = col_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_q     <= '0;
      hold_q    <= '0;
      col_q     <= '0;
      col_idx_q <= '0;
      busy_q    <= 1'b0;
      latch_q   <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      hold_q    <= hold_d;
      col_q     <= col_d;
      col_idx_q <= col_idx_d;
      busy_q    <= (state_d != IDLE);
      latch_q   <= (state_d == LATCH);
      fd_q      <= (state_d == NEXT) && (col_q == LAST_COL);
    end
  end

  // Shifted-out bits are zero-filled, so ser_data rests low outside SHIFT.
  assign ser_data   = shreg_q[ROWS-1];
  assign col_idx    = col_idx_q;
  assign ser_latch  = latch_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule
